// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Holds the FSM state encoding, the idle column strobe and the key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } kp_state_e;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  function automatic logic single_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  // Row/column arrive as one-cold vectors; row 0 is the top row, col 0 the left column.
  function automatic logic [3:0] key_map(input logic [3:0] row_onehot_n,
                                         input logic [3:0] col_onehot_n);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] k;
    r = 2'd0;
    c = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_onehot_n[i]) r = 2'(i);
      if (!col_onehot_n[i]) c = 2'(i);
    end
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and display-side signals of the scanner, bundled as one interface.
// master = scanner (drives strobes and key outputs), slave = keypad/display side.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digit_left;
  logic [3:0] digit_right;

  modport master (
    input  rows,
    output cols, key_code, key_valid, key_held, digit_left, digit_right
  );

  modport slave (
    output rows,
    input  cols, key_code, key_valid, key_held, digit_left, digit_right
  );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value is chosen per instance.
module sync_2ff #(
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, press/release debounce, last-two-key digit shift.
// Optional build macro KEY_REPEAT_EN adds auto-repeat while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 4800,
  parameter int DEBOUNCE_CYC  = 960000,
  parameter int REPEAT_DELAY  = 24000000,
  parameter int REPEAT_PERIOD = 4800000
) (
  input  logic clk,
  input  logic reset_n,
  keypad_scanner_if.master kp
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

  kp_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       cols_q, cols_nx, cols_rot;
  logic [3:0]       row_lat, row_lat_nx;
  logic [3:0]       code_q, code_nx, left_q, left_nx, right_q, right_nx;
  logic             valid_q, valid_nx, held_q, held_nx;
  logic [3:0]       rows_s;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nx;
  logic             rpt_first, rpt_first_nx;
`endif

  sync_2ff #(.DATA_W(4), .RESET_VAL(ROWS_IDLE)) u_rows_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (kp.rows),
    .q       (rows_s)
  );

  assign cols_rot = {cols_q[2:0], cols_q[3]};

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cols_nx    = cols_q;
    row_lat_nx = row_lat;
    code_nx    = code_q;
    left_nx    = left_q;
    right_nx   = right_q;
    valid_nx   = 1'b0;
    held_nx    = held_q;
`ifdef KEY_REPEAT_EN
    rpt_cnt_nx   = rpt_cnt;
    rpt_first_nx = rpt_first;
`endif
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nx = '0;
          if (single_low(rows_s)) begin
            row_lat_nx = rows_s;
            state_nx   = DEB_PRESS;
          end else begin
            cols_nx = cols_rot;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DEB_PRESS: begin
        if (rows_s != row_lat) begin
          state_nx = SCAN;
          cnt_nx   = '0;
          cols_nx  = cols_rot;
        end else if (cnt == DEB_LAST) begin
          code_nx  = key_map(row_lat, cols_q);
          left_nx  = right_q;
          right_nx = key_map(row_lat, cols_q);
          valid_nx = 1'b1;
          held_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = HELD;
`ifdef KEY_REPEAT_EN
          rpt_cnt_nx   = '0;
          rpt_first_nx = 1'b1;
`endif
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (rows_s == ROWS_IDLE) begin
          state_nx = DEB_RELEASE;
          cnt_nx   = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
            valid_nx     = 1'b1;
            left_nx      = right_q;
            right_nx     = code_q;
            rpt_cnt_nx   = '0;
            rpt_first_nx = 1'b0;
          end else begin
            rpt_cnt_nx = rpt_cnt + RPT_W'(1);
          end
`endif
        end
      end
      DEB_RELEASE: begin
        if (rows_s != ROWS_IDLE) begin
          state_nx = HELD;
          cnt_nx   = '0;
`ifdef KEY_REPEAT_EN
          rpt_cnt_nx   = '0;
          rpt_first_nx = 1'b1;
`endif
        end else if (cnt == DEB_LAST) begin
          held_nx  = 1'b0;
          state_nx = SCAN;
          cnt_nx   = '0;
          cols_nx  = cols_rot;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SCAN;
      cnt     <= '0;
      cols_q  <= COL_RESET;
      code_q  <= 4'h0;
      left_q  <= 4'h0;
      right_q <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cols_q  <= cols_nx;
      code_q  <= code_nx;
      left_q  <= left_nx;
      right_q <= right_nx;
      valid_q <= valid_nx;
      held_q  <= held_nx;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= rpt_cnt_nx;
      rpt_first <= rpt_first_nx;
`endif
    end
  end

  // Latched row pattern is only meaningful once DEB_PRESS is entered, so it carries no reset.
  always_ff @(posedge clk) begin
    row_lat <= row_lat_nx;
  end

  assign kp.cols        = cols_q;
  assign kp.key_code    = code_q;
  assign kp.key_valid   = valid_q;
  assign kp.key_held    = held_q;
  assign kp.digit_left  = left_q;
  assign kp.digit_right = right_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a cycle-stepped protocol model and literal spot checks.
// Build with or without KEY_REPEAT_EN; the model and the repeat scenario follow the same macro.
module tb_keypad_scanner;

  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE_CYC  = 16;
  localparam int REPEAT_DELAY  = 40;
  localparam int REPEAT_PERIOD = 20;

  logic clk;
  logic reset_n;
  logic [15:0] pressed;
  logic [3:0]  rows_drv;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_CYC  (DEBOUNCE_CYC),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a pressed key sits on the currently strobed column.
  always_comb begin
    rows_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.cols[c]) rows_drv[r] = 1'b0;
  end
  assign kp.rows = rows_drv;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int pulse_q[$];

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      pulse_q.push_back(cyc);
    end
  end

  // ---------------- protocol model ----------------
  int         m_col;
  logic [3:0] m_code, m_left, m_right, m_latch, m_rs, m_s1, m_cur;
  bit         m_valid, m_held, aborted;

  function automatic int row_of(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) r = i;
    return r;
  endfunction

  function automatic bit one_low(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) n++;
    return n == 1;
  endfunction

  task automatic tick();
    logic [3:0] exp_cols;
    @(negedge clk);
    if (!reset_n) begin
      m_col = 0; m_code = 0; m_left = 0; m_right = 0;
      m_valid = 0; m_held = 0; m_rs = 4'hF; m_s1 = 4'hF;
      aborted = 1;
    end
    exp_cols = 4'hF;
    exp_cols[m_col] = 1'b0;
    check("cols", kp.cols, exp_cols);
    check("key_code", kp.key_code, m_code);
    check("key_valid", kp.key_valid, m_valid);
    check("key_held", kp.key_held, m_held);
    check("digit_left", kp.digit_left, m_left);
    check("digit_right", kp.digit_right, m_right);
    m_valid = 0;
    if (reset_n) begin
      m_cur = m_rs;
      m_rs  = m_s1;
      m_s1  = kp.rows;
    end
  endtask

  task automatic do_scan();
    int d = 0;
    aborted = 0;
    forever begin
      tick();
      if (aborted) begin aborted = 0; d = 0; continue; end
      if (d == SCAN_DIV - 1) begin
        d = 0;
        if (one_low(m_cur)) begin m_latch = m_cur; return; end
        m_col = (m_col + 1) % 4;
      end else d++;
    end
  endtask

  task automatic do_press(output bit ok);
    ok = 0;
    for (int n = 0; n < DEBOUNCE_CYC; n++) begin
      tick();
      if (aborted) return;
      if (m_cur != m_latch) begin m_col = (m_col + 1) % 4; return; end
    end
    m_code  = kmap[row_of(m_latch)*4 + m_col];
    m_left  = m_right;
    m_right = m_code;
    m_valid = 1;
    m_held  = 1;
    ok = 1;
  endtask

  task automatic do_held();
    int r = 0;
    bit first = 1;
    forever begin
      tick();
      if (aborted) return;
      if (m_cur == 4'hF) begin
        for (int m = 0; m < DEBOUNCE_CYC; m++) begin
          tick();
          if (aborted) return;
          if (m_cur != 4'hF) break;
          if (m == DEBOUNCE_CYC - 1) begin
            m_held = 0;
            m_col = (m_col + 1) % 4;
            return;
          end
        end
        r = 0;
        first = 1;
      end else begin
`ifdef KEY_REPEAT_EN
        if (r == (first ? REPEAT_DELAY : REPEAT_PERIOD) - 1) begin
          m_valid = 1;
          m_left  = m_right;
          m_right = m_code;
          r = 0;
          first = 0;
        end else r++;
`endif
      end
    end
  endtask

  initial begin
    bit ok;
    m_col = 0; m_code = 0; m_left = 0; m_right = 0;
    m_valid = 0; m_held = 0; m_rs = 4'hF; m_s1 = 4'hF; m_cur = 4'hF; m_latch = 4'hF;
    aborted = 0;
    forever begin
      do_scan();
      do_press(ok);
      if (!ok) continue;
      do_held();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int base, input int limit, input string name);
    int n = 0;
    while (pulse_cnt == base && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, (pulse_cnt > base), 1);
  endtask

  initial begin
    logic [3:0] col_seq [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    int p0, stop_cyc, run, n, q0;
    reset_n = 1'b1;
    pressed = '0;
    #2 reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;

    // 1: idle scanning
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k % 4 == 0 && k <= 16) check("t1_cols", kp.cols, col_seq[k/4]);
    end
    #1;
    check("t1_no_pulse", pulse_cnt, 0);
    check("t1_code", kp.key_code, 4'h0);

    // 2: clean press of '5'
    p0 = pulse_cnt;
    @(posedge clk); #1;
    pressed[5] = 1'b1;
    cycles(100);
    pressed[5] = 1'b0;
    cycles(40);
    check("t2_pulses", pulse_cnt - p0, 1);
    check("t2_code", kp.key_code, 4'h5);
    check("t2_right", kp.digit_right, 4'h5);
    check("t2_left", kp.digit_left, 4'h0);
    check("t2_held_low", kp.key_held, 1'b0);

    // 3: bouncing '9'
    p0 = pulse_cnt;
    stop_cyc = 0;
    for (int i = 0; i < 15; i++) begin
      pressed[10] = (i % 2 == 0);
      if (i == 14) stop_cyc = cyc;
      cycles(3);
    end
    cycles(80);
    pressed[10] = 1'b0;
    cycles(40);
    check("t3_pulses", pulse_cnt - p0, 1);
    check("t3_code", kp.key_code, 4'h9);
    check("t3_left", kp.digit_left, 4'h5);
    check("t3_late_enough", (last_pulse_cyc >= stop_cyc + 16), 1);

    // 4: '1' then 'A', then a two-key chord on one column
    p0 = pulse_cnt;
    pressed[0] = 1'b1; cycles(80); pressed[0] = 1'b0; cycles(40);
    pressed[3] = 1'b1; cycles(80); pressed[3] = 1'b0; cycles(40);
    check("t4_pulses", pulse_cnt - p0, 2);
    check("t4_left", kp.digit_left, 4'h1);
    check("t4_right", kp.digit_right, 4'hA);
    p0 = pulse_cnt;
    pressed[1] = 1'b1; pressed[5] = 1'b1;
    cycles(80);
    pressed[1] = 1'b0; pressed[5] = 1'b0;
    cycles(40);
    check("t4_chord_pulses", pulse_cnt - p0, 0);
    check("t4_chord_right", kp.digit_right, 4'hA);

    // 5: reset during press debounce of '0'
    p0 = pulse_cnt;
    pressed[13] = 1'b1;
    run = 0; n = 0;
    while (run < 6 && n < 200) begin
      @(negedge clk);
      n++;
      if (kp.cols === 4'b1101) run++; else run = 0;
    end
    check("t5_debounce_entered", (run >= 6), 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_cols", kp.cols, 4'hE);
    check("t5_rst_valid", kp.key_valid, 1'b0);
    check("t5_rst_held", kp.key_held, 1'b0);
    check("t5_rst_right", kp.digit_right, 4'h0);
    cycles(2);
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_post_cols", kp.cols, 4'hE);
    check("t5_no_pulse_in_reset", pulse_cnt - p0, 0);
    cycles(80);
    pressed[13] = 1'b0;
    cycles(40);
    check("t5_pulses", pulse_cnt - p0, 1);
    check("t5_code", kp.key_code, 4'h0);
    check("t5_left", kp.digit_left, 4'h0);

    // 6: long hold of 'F'
    p0 = pulse_cnt;
    q0 = pulse_q.size();
    pressed[14] = 1'b1;
    wait_pulse(p0, 200, "t6_accept_timeout");
    cycles(110);
    pressed[14] = 1'b0;
    cycles(40);
    check("t6_code", kp.key_code, 4'hF);
    check("t6_right", kp.digit_right, 4'hF);
`ifdef KEY_REPEAT_EN
    check("t6_pulses", pulse_cnt - p0, 5);
    if (pulse_q.size() >= q0 + 5) begin
      check("t6_rep1", pulse_q[q0+1] - pulse_q[q0], 40);
      check("t6_rep2", pulse_q[q0+2] - pulse_q[q0], 60);
      check("t6_rep3", pulse_q[q0+3] - pulse_q[q0], 80);
      check("t6_rep4", pulse_q[q0+4] - pulse_q[q0], 100);
    end
    check("t6_left", kp.digit_left, 4'hF);
`else
    check("t6_pulses", pulse_cnt - p0, 1);
    check("t6_left", kp.digit_left, 4'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
